// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - obstacle slot pool: spawn, scroll, retire; optional DIFFICULTY_RAMP_EN speed ramp
module obstacle_scheduler #(
  parameter int NSLOT      = 4,
  parameter int SPAWN_X    = 640,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 8,
  parameter int SPEED_STEP = 5,
  parameter int MIN_GAP    = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic                 collide,
  output logic [1:0]           state,
  output logic [NSLOT-1:0]     obs_valid,
  output logic [NSLOT*10-1:0]  obs_x,
  output logic [NSLOT*2-1:0]   obs_type,
  output logic [3:0]           speed,
  output logic                 pass_pulse,
  output logic [15:0]          pass_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  localparam logic [9:0]  SPAWN_X10 = 10'(SPAWN_X);
  // Speed register is 4 bits and must never be 0; start value is clamped under the ceiling.
  localparam int          SPEED_TOP  = (SPEED_MAX > 15) ? 15 : SPEED_MAX;
  localparam int          SPEED_BASE = (SPEED_INIT < 1) ? 1 :
                                       ((SPEED_INIT > SPEED_TOP) ? SPEED_TOP : SPEED_INIT);
  localparam logic [3:0]  SPEED_LO   = 4'(SPEED_BASE);
  localparam int          STEP_W     = $clog2(SPEED_STEP + 1);
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  logic [15:0]         gap_q, gap_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [1:0]          state_d;
  logic [NSLOT-1:0]    valid_d;
  logic [NSLOT*10-1:0] x_d;
  logic [NSLOT*2-1:0]  type_d;
  logic [3:0]          speed_d;
  logic                pulse_d;
  logic [15:0]         cnt_d;
  logic [3:0]          retire_n;
  logic                spawned;
  logic [16:0]         cnt_sum;
  logic [9:0]          slot_x;

  // Next-state: mode changes, per-tick retire/scroll/spawn, LFSR and pass accounting
  always_comb begin
    state_d  = state;
    valid_d  = obs_valid;
    x_d      = obs_x;
    type_d   = obs_type;
    speed_d  = speed;
    pulse_d  = 1'b0;
    cnt_d    = pass_cnt;
    gap_d    = gap_q;
    lfsr_d   = lfsr_q;
    step_d   = step_q;
    retire_n = 4'd0;
    spawned  = 1'b0;
    cnt_sum  = 17'd0;
    slot_x   = 10'd0;
    case (state)
      ST_IDLE, ST_FROZEN: begin
        if (start) begin
          state_d = ST_RUN;
          valid_d = '0;
          x_d     = '0;
          type_d  = '0;
          cnt_d   = 16'd0;
          speed_d = SPEED_LO;
          gap_d   = 16'd0;
          step_d  = '0;
        end
      end
      ST_RUN: begin
        if (collide) begin
          // Collision beats a coincident tick: the board freezes exactly as it stands.
          state_d = ST_FROZEN;
        end else if (frame_tick) begin
          for (int i = 0; i < NSLOT; i++) begin
            slot_x = obs_x[i*10 +: 10];
            if (obs_valid[i]) begin
              if (slot_x <= {6'd0, speed}) begin
                valid_d[i] = 1'b0;
                retire_n   = retire_n + 4'd1;
`ifdef DIFFICULTY_RAMP_EN
                if (step_d == STEP_W'(SPEED_STEP - 1)) begin
                  step_d = '0;
                  if (speed_d < 4'(SPEED_TOP)) speed_d = speed_d + 4'd1;
                end else begin
                  step_d = step_d + STEP_W'(1);
                end
`endif
              end else begin
                x_d[i*10 +: 10] = slot_x - {6'd0, speed};
              end
            end
          end
          if (gap_q != 16'd0) begin
            gap_d = gap_q - 16'd1;
          end else begin
            // Only slots free before this tick are candidates, so a just-retired slot waits a tick.
            for (int i = 0; i < NSLOT; i++) begin
              if (!obs_valid[i] && !spawned) begin
                spawned             = 1'b1;
                valid_d[i]          = 1'b1;
                x_d[i*10 +: 10]     = SPAWN_X10;
                type_d[i*2 +: 2]    = lfsr_q[1:0];
                gap_d               = 16'(MIN_GAP) + {11'd0, lfsr_q[4:0]};
              end
            end
          end
          lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
          cnt_sum = {1'b0, pass_cnt} + {13'd0, retire_n};
          cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
          pulse_d = (retire_n != 4'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      obs_valid  <= '0;
      obs_x      <= '0;
      obs_type   <= '0;
      speed      <= SPEED_LO;
      pass_pulse <= 1'b0;
      pass_cnt   <= 16'd0;
      gap_q      <= 16'd0;
      lfsr_q     <= LFSR_SEED;
      step_q     <= '0;
    end else begin
      state      <= state_d;
      obs_valid  <= valid_d;
      obs_x      <= x_d;
      obs_type   <= type_d;
      speed      <= speed_d;
      pass_pulse <= pulse_d;
      pass_cnt   <= cnt_d;
      gap_q      <= gap_d;
      lfsr_q     <= lfsr_d;
      step_q     <= step_d;
    end
  end

endmodule
